// File: rtl/dbus_bridge.sv
// -----------------------------------------------------------------------------
// dbus_bridge
//
// Bridges the CPU core's memory-stage data interface onto a registered
// request/ready memory port. Each core access becomes one memory transaction.
// The core is stalled through HLT until that transaction finishes.
//
// Ports
//   CLK, RES        clock, synchronous active-high reset
//   DADDR, DATAO    core address and right-justified store data
//   DLEN            access size (1 = byte, 2 = half, 4 = word)
//   DRD, DWR        core read / write request (DWR wins if both are high)
//   DATAI           raw aligned read word returned to the core
//   HLT             core stall
//   BERR            access error (misaligned, slave error or timeout),
//                   valid for the single DONE cycle
//   m_req .. m_wdata  memory request side; m_addr is always word aligned
//   m_ready, m_rdata, m_err  memory response side
// -----------------------------------------------------------------------------
module dbus_bridge #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [2:0]  DLEN,
  input  logic        DRD,
  input  logic        DWR,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic        BERR,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter value seen on the last wait cycle allowed before the abort.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          datai_q, datai_d;
  logic                 berr_q, berr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 hlt_raw;

  // Access decode for the request currently presented by the core.
  logic       is_byte, is_half, is_word, misaligned;
  logic [3:0] be_new;
  logic [31:0] wdata_new;

  assign is_byte    = (DLEN == 3'd1);
  assign is_half    = (DLEN == 3'd2);
  assign is_word    = (DLEN == 3'd4);
  // Illegal DLEN falls out here too, since none of the legal terms match.
  assign misaligned = !(is_byte ||
                        (is_half && !DADDR[0]) ||
                        (is_word && (DADDR[1:0] == 2'b00)));

  // Per-lane enable and store-data steering. Byte data is replicated into
  // every lane and half data into both halves, so the slave just uses m_be.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be_new[gi] = is_word ||
                          (is_half && (DADDR[1] == LANE[1])) ||
                          (is_byte && (DADDR[1:0] == LANE));
      assign wdata_new[gi*8 +: 8] = is_byte ? DATAO[7:0] :
                                    is_half ? DATAO[(gi % 2)*8 +: 8] :
                                              DATAO[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    datai_d = datai_q;
    berr_d  = berr_q;
    cnt_d   = cnt_q;
    hlt_raw = 1'b0;

    case (state_q)
      S_IDLE: begin
        hlt_raw = DRD | DWR;
        berr_d  = 1'b0;
        if (DRD || DWR) begin
          addr_d  = {DADDR[31:2], 2'b00};
          we_d    = DWR;
          be_d    = be_new;
          wdata_d = wdata_new;
          cnt_d   = '0;
          if (misaligned) begin
            // Rejected locally; the memory port never sees this access.
            berr_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        hlt_raw = 1'b1;
        if (m_ready) begin
          if (!we_q) begin
            datai_d = m_rdata;
          end
          berr_d  = m_err;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (m_err) begin
          berr_d  = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            berr_d  = 1'b1;
            req_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Core advances on this edge; DRD/DWR still belong to this access.
        berr_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        req_d   = 1'b0;
        berr_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      datai_q <= '0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      datai_q <= datai_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign HLT     = hlt_raw & ~RES;
  assign m_req   = req_q;
  assign m_we    = we_q;
  assign m_be    = be_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign DATAI   = datai_q;
  assign BERR    = berr_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dbus_bridge
//
// Directed and randomized accesses against dbus_bridge (TIMEOUT = 4). A small
// reference model derives byte enables, steered write data, error outcome,
// stall length and the DATAI value from the access rules directly.
// -----------------------------------------------------------------------------
module tb_dbus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        RES;
  logic [31:0] DADDR, DATAO, DATAI, m_addr, m_wdata, m_rdata;
  logic [2:0]  DLEN;
  logic        DRD, DWR, HLT, BERR, m_req, m_we, m_ready, m_err;
  logic [3:0]  m_be;

  int errors = 0;
  int checks = 0;
  int txn    = 0;
  logic [31:0] datai_model;

  dbus_bridge #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .CLK(clk), .RES(RES), .DADDR(DADDR), .DATAO(DATAO), .DLEN(DLEN),
    .DRD(DRD), .DWR(DWR), .DATAI(DATAI), .HLT(HLT), .BERR(BERR),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode: 0 = m_ready after wait_n wait cycles, 1 = m_err alone after wait_n,
  //       2 = slave silent (timeout)
  task automatic access(input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] len, input bit rd, input bit wr,
                        input int mode, input int wait_n,
                        input logic [31:0] rdata, input bit err_rdy);
    bit          legal;
    bit          exp_berr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          hlt_seen;
    int          req_seen;
    int          exp_req_cycles;
    legal = (len == 1) || (len == 2 && addr % 2 == 0) || (len == 4 && addr % 4 == 0);
    case (len)
      3'd1:    begin exp_be = 4'(1 << (addr % 4)); exp_wd = {24'b0, data[7:0]} * 32'h01010101; end
      3'd2:    begin exp_be = 4'(3 << (addr & 2)); exp_wd = {16'b0, data[15:0]} * 32'h00010001; end
      default: begin exp_be = 4'hF;                exp_wd = data; end
    endcase
    hlt_seen = 0;
    req_seen = 0;
    exp_berr = 1'b1;
    exp_req_cycles = 0;

    // IDLE cycle: request presented, stall must appear combinationally.
    @(negedge clk);
    DADDR = addr; DATAO = data; DLEN = len; DRD = rd; DWR = wr;
    m_ready = 1'b0; m_err = 1'b0;
    #1;
    chk("idle_hlt", HLT, 1);
    chk("idle_req", m_req, 0);
    hlt_seen += int'(HLT);

    if (legal) begin
      exp_req_cycles = (mode == 2) ? TO : wait_n + 1;
      for (int k = 0; k < TO; k++) begin
        @(negedge clk);
        m_ready = 1'b0; m_err = 1'b0;
        #1;
        hlt_seen += int'(HLT);
        req_seen += int'(m_req);
        chk("req_addr", m_addr, {addr[31:2], 2'b00});
        chk("req_be", m_be, exp_be);
        chk("req_we", m_we, wr);
        if (wr) chk("req_wdata", m_wdata, exp_wd);
        if (mode == 0 && k == wait_n) begin
          m_ready = 1'b1; m_rdata = rdata; m_err = err_rdy;
          exp_berr = err_rdy;
          if (!wr) datai_model = rdata;
          break;
        end
        if (mode == 1 && k == wait_n) begin
          m_err = 1'b1;
          break;
        end
      end
    end

    // DONE cycle: core request still held, must be ignored.
    @(negedge clk);
    m_ready = 1'b0; m_err = 1'b0; m_rdata = $urandom;
    #1;
    hlt_seen += int'(HLT);
    req_seen += int'(m_req);
    chk("done_berr", BERR, exp_berr);
    chk("done_datai", DATAI, datai_model);
    chk("hlt_cycles", hlt_seen, legal ? exp_req_cycles + 1 : 1);
    chk("req_cycles", req_seen, exp_req_cycles);

    // Back in IDLE with no request.
    @(negedge clk);
    DRD = 1'b0; DWR = 1'b0;
    #1;
    chk("after_berr", BERR, 0);
    chk("after_hlt", HLT, 0);
    chk("after_datai", DATAI, datai_model);
    txn++;
    $display("txn %0d addr=%h len=%0d rd=%0d wr=%0d mode=%0d wait=%0d berr=%0d datai=%h",
             txn, addr, len, rd, wr, mode, wait_n, exp_berr, datai_model);
  endtask

  initial begin
    logic [2:0] len_tab [10];
    len_tab = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd5, 3'd7};

    RES = 1'b1; DADDR = '0; DATAO = '0; DLEN = 3'd4; DRD = 1'b1; DWR = 1'b0;
    m_ready = 1'b0; m_rdata = '0; m_err = 1'b0;
    datai_model = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hlt_forced", HLT, 0);
    chk("rst_req", m_req, 0);
    chk("rst_be", m_be, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_datai", DATAI, 0);
    chk("rst_berr", BERR, 0);
    @(negedge clk);
    RES = 1'b0; DRD = 1'b0;

    // Directed cases
    access(32'h00001004, 32'h0, 3'd4, 1, 0, 0, 2, 32'hDEADBEEF, 0);
    access(32'h00002003, 32'h000000AB, 3'd1, 0, 1, 0, 0, 32'h0, 0);
    access(32'h00002002, 32'h00001234, 3'd2, 0, 1, 0, 1, 32'h0, 0);
    access(32'h00003001, 32'h0, 3'd2, 1, 0, 0, 0, 32'h0, 0);
    access(32'h00003000, 32'h0, 3'd3, 1, 0, 0, 0, 32'h0, 0);
    access(32'h00005008, 32'h0, 3'd4, 1, 0, 2, 0, 32'h0, 0);
    access(32'h00006001, 32'h0, 3'd1, 1, 0, 1, 1, 32'h0, 0);
    access(32'h00007002, 32'h0, 3'd2, 1, 0, 0, 3, 32'h13572468, 1);

    // Reset during the second REQ cycle, late m_ready ignored.
    @(negedge clk);
    DADDR = 32'h00004000; DLEN = 3'd4; DRD = 1'b1; DWR = 1'b0;
    @(negedge clk);
    #1;
    chk("rstreq_req", m_req, 1);
    @(negedge clk);
    RES = 1'b1;
    #1;
    chk("rstreq_hlt_forced", HLT, 0);
    @(negedge clk);
    RES = 1'b0; DRD = 1'b0; m_ready = 1'b1; m_rdata = 32'h5555AAAA;
    #1;
    datai_model = '0;
    chk("rstreq_m_req", m_req, 0);
    chk("rstreq_hlt", HLT, 0);
    chk("rstreq_be", m_be, 0);
    chk("rstreq_addr", m_addr, 0);
    chk("rstreq_we", m_we, 0);
    chk("rstreq_wdata", m_wdata, 0);
    chk("rstreq_datai", DATAI, 0);
    chk("rstreq_berr", BERR, 0);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("late_ready_datai", DATAI, 0);
    chk("late_ready_req", m_req, 0);
    access(32'h0000100C, 32'h0, 3'd4, 1, 0, 0, 0, 32'hCAFEF00D, 0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      int sel, m, w;
      logic [31:0] a, d, r;
      bit rd_b, wr_b, e;
      sel = $urandom_range(0, 2);
      rd_b = (sel != 1);
      wr_b = (sel != 0);
      m = $urandom_range(0, 5);
      m = (m < 4) ? 0 : m - 3;
      w = $urandom_range(0, TO - 1);
      a = $urandom; d = $urandom; r = $urandom;
      e = ($urandom_range(0, 7) == 0);
      access(a, d, len_tab[$urandom_range(0, 9)], rd_b, wr_b, m, w, r, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Sits directly downstream of the CPU core's memory stage, between the core's data interface (DADDR/DATAO/DLEN/DRD/DWR) and the SoC data memory/peripheral port.
- Converts each core access into a registered request/ready transaction.
- Generates byte enables and lane-replicated write data, and returns the raw read word.
- Stalls the core through HLT until each transaction completes; reports misalignment, slave error and timeout through BERR.

Parameters:
- TIMEOUT_W, 8: width of the wait-state counter.
- TIMEOUT, 255: cycles in REQ without m_ready or m_err before the access is aborted. Must be at least 1 and at most 2^TIMEOUT_W - 1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RES  in  1  synchronous active-high reset.
- DADDR  in  32  core data address.
- DATAO  in  32  core store data, right-justified.
- DLEN  in  3  access size: 1 = byte, 2 = half, 4 = word; any other value is illegal.
- DRD  in  1  core read request.
- DWR  in  1  core write request.
- DATAI  out  32  raw aligned memory word returned to the core.
- HLT  out  1  core stall.
- BERR  out  1  access error, valid in DONE.
- m_req  out  1  memory request.
- m_we  out  1  1 = write.
- m_be  out  4  byte enables.
- m_addr  out  32  word address; bits [1:0] are always 0.
- m_wdata  out  32  lane-steered store data.
- m_ready  in  1  slave completes the transaction this cycle.
- m_rdata  in  32  read data, valid with m_ready.
- m_err  in  1  slave error, valid with m_ready or alone.

Behaviour:
- Reset:
  - State returns to IDLE.
  - m_req, m_we, m_be, m_addr, m_wdata, DATAI, BERR and the timeout counter all clear to 0.
  - HLT is forced to 0 while RES = 1.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - HLT = DRD | DWR, combinational, so a new access stalls the core in the same cycle.
  - On DRD | DWR, register m_addr = {DADDR[31:2], 2'b00}, m_we = DWR, m_be and m_wdata. DWR wins if both DRD and DWR are high.
  - Legal access -> REQ. Misaligned or illegal-DLEN access -> DONE with BERR = 1; m_req is never raised.
- Misaligned means any of: DLEN = 2 with DADDR[0] = 1; DLEN = 4 with DADDR[1:0] != 0; DLEN not in {1, 2, 4}.
- Byte enables:
  - Byte: 4'b0001 << DADDR[1:0].
  - Half: 4'b0011 << {DADDR[1], 1'b0}.
  - Word: 4'b1111.
  - Reads drive the same m_be.
- Write data:
  - Byte: DATAO[7:0] replicated into all 4 lanes.
  - Half: DATAO[15:0] replicated into both halves.
  - Word: DATAO unchanged.
- REQ:
  - m_req = 1 and HLT = 1; address, enables and data are held stable.
  - The counter increments each cycle m_ready = 0 and m_err = 0.
  - m_ready = 1 -> capture DATAI = m_rdata (reads only; writes leave DATAI unchanged), BERR = m_err, go to DONE.
  - m_err = 1 with m_ready = 0 -> BERR = 1, go to DONE.
  - Counter reaches TIMEOUT -> BERR = 1, go to DONE, DATAI unchanged.
  - m_req drops on the transition out of REQ.
- DONE:
  - HLT = 0 and m_req = 0, so the core advances on this edge.
  - DATAI and BERR are valid for this single cycle; DATAI then holds its value, BERR clears on leaving DONE.
  - Always returns to IDLE; the counter clears.
  - DRD/DWR seen during DONE belong to the completing access and are ignored.
- Back-to-back accesses therefore cost a minimum of 3 cycles each: IDLE, REQ with zero wait, DONE.
- Reset mid-transaction: RES in REQ aborts the access. m_req is 0 after the reset edge; any later m_ready or m_rdata is ignored.
- m_ready outside REQ is ignored.
- The block performs no sign extension or byte extraction; the core aligns DATAI.

Test Plan:
- Word read, DADDR = 0x00001004, DLEN = 4, m_ready 2 cycles late with m_rdata = 0xDEADBEEF -> m_addr = 0x00001004, m_be = 1111, m_we = 0; HLT high for 4 cycles; DATAI = 0xDEADBEEF in DONE; BERR = 0.
- Byte store, DADDR = 0x00002003, DATAO = 0x000000AB, DLEN = 1, immediate m_ready -> m_be = 1000, m_wdata = 0xABABABAB, m_we = 1, m_addr = 0x00002000; HLT high 2 cycles.
- Half store, DADDR = 0x00002002, DATAO = 0x00001234 -> m_be = 1100, m_wdata = 0x12341234.
- Misaligned half read at 0x00003001 -> m_req never asserted; BERR = 1 for one cycle; HLT high exactly 1 cycle. DLEN = 3 gives the same response.
- Slave never answers, TIMEOUT = 4 -> m_req high 4 cycles then drops; BERR = 1 in DONE; DATAI retains its previous value.
- RES asserted on the 2nd REQ cycle, m_ready arriving next cycle -> m_req = 0, HLT = 0, all outputs 0, state IDLE; the late m_ready is ignored. A following word read completes normally.
